team_06_i2s_clkgen: RTL and testbench

//  Parametrised I2S clock generator; successor to the fixed divide-by-24 i2sclk divider.

---
 rtl/team_06_i2s_clkgen_if.sv | 30 +++
 rtl/team_06_i2s_clkgen.sv | 163 ++++++++++++++++
 tb/tb_team_06_i2s_clkgen.sv | 240 ++++++++++++++++++++++++
 3 files changed

// File: rtl/team_06_i2s_clkgen_if.sv
// I2S clock generator bus: run control in, bit/word clocks and shifter strobes out.
interface team_06_i2s_clkgen_if #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned SLOT_BITS = 32
) ();
  localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;

  logic             en;
  logic [DIV_W-1:0] div_half;
  logic             bclk;
  logic             lrclk;
  logic             bclk_rise;
  logic             bclk_fall;
  logic             frame_start;
  logic             slot;
  logic [BIT_W-1:0] bit_idx;
  logic             busy;

  // Clock generator side
  modport master (
    input  en, div_half,
    output bclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx, busy
  );

  // Controller / shifter side
  modport slave (
    output en, div_half,
    input  bclk, lrclk, bclk_rise, bclk_fall, frame_start, slot, bit_idx, busy
  );
endinterface

// File: rtl/team_06_i2s_clkgen.sv
// Programmable I2S BCLK/LRCLK generator with start/stop control and
// frame-aligned divider reload; all outputs come straight from flops.
module team_06_i2s_clkgen #(
  parameter int unsigned DIV_W     = 8,
  parameter int unsigned SLOT_BITS = 32,
  parameter int unsigned I2S_DELAY = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  team_06_i2s_clkgen_if.master  bus
);

  localparam int unsigned BIT_W = (SLOT_BITS > 1) ? $clog2(SLOT_BITS) : 1;
  localparam logic [BIT_W-1:0] LAST_BIT = BIT_W'(SLOT_BITS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_STOP = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
  logic             bclk_q, bclk_d;
  logic             lrclk_q, lrclk_d;
  logic             bclk_rise_q, bclk_rise_d;
  logic             bclk_fall_q, bclk_fall_d;
  logic             frame_start_q, frame_start_d;
  logic             slot_q, slot_d;
  logic [BIT_W-1:0] bit_idx_q, bit_idx_d;
  logic             busy_q, busy_d;

  logic [DIV_W-1:0] div_load;
  logic             toggle;
  logic             last_bit;
  logic             frame_end;

  // Word select leads the slot boundary by one bit in Philips mode
  function automatic logic lr_of(input logic [BIT_W-1:0] bi, input logic sl);
    if ((I2S_DELAY != 0) && (bi == LAST_BIT)) begin
      return ~sl;
    end
    return sl;
  endfunction

  always_comb begin
    div_load  = (bus.div_half == '0) ? DIV_W'(1) : bus.div_half;
    toggle    = (div_cnt_q == (div_q - DIV_W'(1)));
    last_bit  = (bit_idx_q == LAST_BIT);
    frame_end = toggle && bclk_q && last_bit && slot_q;
  end

  // Next-state and output computation
  always_comb begin
    state_d       = state_q;
    div_d         = div_q;
    div_cnt_d     = div_cnt_q;
    bclk_d        = bclk_q;
    lrclk_d       = lrclk_q;
    bclk_rise_d   = 1'b0;
    bclk_fall_d   = 1'b0;
    frame_start_d = 1'b0;
    slot_d        = slot_q;
    bit_idx_d     = bit_idx_q;
    busy_d        = busy_q;

    unique case (state_q)
      ST_IDLE: begin
        if (bus.en) begin
          state_d       = ST_RUN;
          div_d         = div_load;
          div_cnt_d     = '0;
          bclk_d        = 1'b0;
          lrclk_d       = 1'b0;
          slot_d        = 1'b0;
          bit_idx_d     = '0;
          frame_start_d = 1'b1;
          busy_d        = 1'b1;
        end
      end

      ST_RUN, ST_STOP: begin
        state_d = bus.en ? ST_RUN : ST_STOP;

        if (toggle) begin
          div_cnt_d = '0;
          bclk_d    = ~bclk_q;
          if (!bclk_q) begin
            bclk_rise_d = 1'b1;
          end else begin
            bclk_fall_d = 1'b1;
            bit_idx_d   = last_bit ? '0 : bit_idx_q + BIT_W'(1);
            slot_d      = last_bit ? ~slot_q : slot_q;
          end
        end else begin
          div_cnt_d = div_cnt_q + DIV_W'(1);
        end

        lrclk_d = lr_of(bit_idx_d, slot_d);

        // Frame boundary: the only point the divider may change
        if (frame_end) begin
          if ((state_q == ST_STOP) && !bus.en) begin
            state_d     = ST_IDLE;
            div_cnt_d   = '0;
            bclk_d      = 1'b0;
            lrclk_d     = 1'b0;
            bclk_fall_d = 1'b0;
            slot_d      = 1'b0;
            bit_idx_d   = '0;
            busy_d      = 1'b0;
          end else begin
            frame_start_d = 1'b1;
            div_d         = div_load;
          end
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      div_q         <= DIV_W'(1);
      div_cnt_q     <= '0;
      bclk_q        <= 1'b0;
      lrclk_q       <= 1'b0;
      bclk_rise_q   <= 1'b0;
      bclk_fall_q   <= 1'b0;
      frame_start_q <= 1'b0;
      slot_q        <= 1'b0;
      bit_idx_q     <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      div_q         <= div_d;
      div_cnt_q     <= div_cnt_d;
      bclk_q        <= bclk_d;
      lrclk_q       <= lrclk_d;
      bclk_rise_q   <= bclk_rise_d;
      bclk_fall_q   <= bclk_fall_d;
      frame_start_q <= frame_start_d;
      slot_q        <= slot_d;
      bit_idx_q     <= bit_idx_d;
      busy_q        <= busy_d;
    end
  end

  assign bus.bclk        = bclk_q;
  assign bus.lrclk       = lrclk_q;
  assign bus.bclk_rise   = bclk_rise_q;
  assign bus.bclk_fall   = bclk_fall_q;
  assign bus.frame_start = frame_start_q;
  assign bus.slot        = slot_q;
  assign bus.bit_idx     = bit_idx_q;
  assign bus.busy        = busy_q;

endmodule

// File: tb/tb_team_06_i2s_clkgen.sv
// Bench for team_06_i2s_clkgen: three configurations checked every cycle against
// a frame-time model, plus directed literal timing checks.
module tb_team_06_i2s_clkgen;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  team_06_i2s_clkgen_if #(.DIV_W(8), .SLOT_BITS(32)) ifa ();
  team_06_i2s_clkgen_if #(.DIV_W(8), .SLOT_BITS(4))  ifb ();
  team_06_i2s_clkgen_if #(.DIV_W(8), .SLOT_BITS(4))  ifc ();

  team_06_i2s_clkgen #(.DIV_W(8), .SLOT_BITS(32), .I2S_DELAY(1)) dut_a (.clk(clk), .rst(rst), .bus(ifa));
  team_06_i2s_clkgen #(.DIV_W(8), .SLOT_BITS(4),  .I2S_DELAY(1)) dut_b (.clk(clk), .rst(rst), .bus(ifb));
  team_06_i2s_clkgen #(.DIV_W(8), .SLOT_BITS(4),  .I2S_DELAY(0)) dut_c (.clk(clk), .rst(rst), .bus(ifc));

  logic       en_v [3];
  logic [7:0] dh_v [3];
  assign ifa.en = en_v[0];  assign ifa.div_half = dh_v[0];
  assign ifb.en = en_v[1];  assign ifb.div_half = dh_v[1];
  assign ifc.en = en_v[2];  assign ifc.div_half = dh_v[2];

  // {busy, bclk, lrclk, rise, fall, frame_start, slot, bit_idx[4:0]}
  logic [11:0] act [3];
  assign act[0] = {ifa.busy, ifa.bclk, ifa.lrclk, ifa.bclk_rise, ifa.bclk_fall,
                   ifa.frame_start, ifa.slot, ifa.bit_idx};
  assign act[1] = {ifb.busy, ifb.bclk, ifb.lrclk, ifb.bclk_rise, ifb.bclk_fall,
                   ifb.frame_start, ifb.slot, 3'b000, ifb.bit_idx};
  assign act[2] = {ifc.busy, ifc.bclk, ifc.lrclk, ifc.bclk_rise, ifc.bclk_fall,
                   ifc.frame_start, ifc.slot, 3'b000, ifc.bit_idx};

  int n_pass  = 0;
  int n_total = 0;
  int n_print = 0;
  int cyc     = 0;
  bit chk_en  = 1'b0;

  int sbs [3] = '{32, 4, 4};
  int dly [3] = '{1, 1, 0};

  // Model: 0 idle, 1 running, 2 stopping; t = clk cycles since frame start
  int m_st [3] = '{0, 0, 0};
  int m_t  [3] = '{0, 0, 0};
  int m_d  [3] = '{1, 1, 1};
  bit m_fr [3] = '{1'b0, 1'b0, 1'b0};
  logic [11:0] e_v;

  localparam int S_AFS = 0, S_ARISE = 1, S_BFS = 2, S_BFALL = 3, S_BRISE = 4, S_CFS = 5;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int a, input int e);
    n_total++;
    if (a == e) n_pass++;
    else $display("FAIL %s cyc=%0d actual=%0d required=%0d", name, cyc, a, e);
  endtask

  // Expected outputs derived purely from position within the frame
  function automatic logic [11:0] expv(input int st, input int t, input int d,
                                        input bit fresh, input int sb, input int dl);
    int h, p, bi, sl, lr;
    bit on, rise, fall;
    if (st == 0) return 12'd0;
    h    = t / d;
    on   = (t % d) == 0;
    rise = on && (h % 2 == 1);
    fall = on && (h % 2 == 0) && !(t == 0 && fresh);
    p    = h / 2;
    bi   = p % sb;
    sl   = (p / sb) % 2;
    lr   = (dl != 0 && bi == sb - 1) ? 1 - sl : sl;
    return {1'b1, 1'(h % 2), 1'(lr), rise, fall, 1'(t == 0), 1'(sl), 5'(bi)};
  endfunction

  always @(posedge clk) begin
    if (rst) chk_en = 1'b1;
    for (int i = 0; i < 3; i++) begin
      if (rst) begin
        m_st[i] = 0;
      end else if (m_st[i] == 0) begin
        if (en_v[i]) begin
          m_st[i] = 1; m_t[i] = 0; m_fr[i] = 1'b1;
          m_d[i]  = (dh_v[i] == 0) ? 1 : int'(dh_v[i]);
        end
      end else if (m_t[i] + 1 == 4 * sbs[i] * m_d[i]) begin
        if (m_st[i] == 2 && !en_v[i]) begin
          m_st[i] = 0;
        end else begin
          m_st[i] = en_v[i] ? 1 : 2; m_t[i] = 0; m_fr[i] = 1'b0;
          m_d[i]  = (dh_v[i] == 0) ? 1 : int'(dh_v[i]);
        end
      end else begin
        m_t[i]  = m_t[i] + 1;
        m_st[i] = en_v[i] ? 1 : 2;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      for (int i = 0; i < 3; i++) begin
        e_v = expv(m_st[i], m_t[i], m_d[i], m_fr[i], sbs[i], dly[i]);
        n_total++;
        if (act[i] === e_v) n_pass++;
        else begin
          if (n_print < 40)
            $display("FAIL model_dut%0d cyc=%0d actual=%b required=%b", i, cyc, act[i], e_v);
          n_print++;
        end
      end
    end
  end

  function automatic bit sig(input int sel);
    case (sel)
      S_AFS:   return ifa.frame_start;
      S_ARISE: return ifa.bclk_rise;
      S_BFS:   return ifb.frame_start;
      S_BFALL: return ifb.bclk_fall;
      S_BRISE: return ifb.bclk_rise;
      default: return ifc.frame_start;
    endcase
  endfunction

  task automatic wait_for(input int sel, input int budget, output int at);
    at = -1;
    for (int k = 0; k < budget; k++) begin
      @(negedge clk);
      if (sig(sel)) begin
        at = cyc;
        return;
      end
    end
    chk($sformatf("timeout_sel%0d", sel), 0, 1);
  endtask

  initial begin
    int e, r1, r2, f2, x, falls, fs_extra, nr;
    int rises [2];
    logic prev;

    for (int i = 0; i < 3; i++) begin en_v[i] = 1'b0; dh_v[i] = 8'd24; end
    rst = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_busy_a", ifa.busy, 0);
    chk("rst_bclk_b", ifb.bclk, 0);
    chk("rst_bit_a", int'(ifa.bit_idx), 0);
    rst = 1'b0;

    // Legacy divide-by-24 timing on the 32-bit slot config
    en_v[0] = 1'b1;
    wait_for(S_AFS, 5, e);
    wait_for(S_ARISE, 60, r1);
    chk("a_first_rise", r1 - e, 24);
    wait_for(S_ARISE, 60, r2);
    chk("a_period", r2 - r1, 48);
    wait_for(S_AFS, 4000, f2);
    chk("a_frame_len", f2 - e, 3072);
    en_v[0] = 1'b0;

    // Philips word-select lead on 4-bit slots
    dh_v[1] = 8'd2; en_v[1] = 1'b1;
    wait_for(S_BFS, 5, e);
    wait_for(S_BFALL, 40, x);
    wait_for(S_BFALL, 40, x);
    chk("b_lr_fall2", ifb.lrclk, 0);
    wait_for(S_BFALL, 40, x);
    chk("b_lr_fall3", ifb.lrclk, 1);
    chk("b_bit_fall3", int'(ifb.bit_idx), 3);
    chk("b_slot_fall3", ifb.slot, 0);
    wait_for(S_BFALL, 40, x);
    chk("b_slot_fall4", ifb.slot, 1);
    chk("b_lr_fall4", ifb.lrclk, 1);
    wait_for(S_BFALL, 40, x);
    dh_v[1] = 8'd5;
    wait_for(S_BRISE, 40, r1);
    wait_for(S_BRISE, 40, r2);
    chk("b_period_old", r2 - r1, 4);
    wait_for(S_BFS, 100, e);

    // New divider after reload, then stop mid-frame and let it drain
    prev = ifb.bclk; falls = 0; fs_extra = 0; nr = 0; rises[0] = 0; rises[1] = 0;
    for (int k = 0; k < 200; k++) begin
      @(negedge clk);
      if (ifb.bclk_rise && nr < 2) begin rises[nr] = cyc; nr++; end
      if (prev && !ifb.bclk) falls++;
      if (ifb.frame_start) fs_extra++;
      prev = ifb.bclk;
      if (falls == 1 && en_v[1]) begin
        chk("b_stop_bit", int'(ifb.bit_idx), 1);
        chk("b_stop_slot", ifb.slot, 0);
        en_v[1] = 1'b0;
      end
      if (!ifb.busy) break;
    end
    chk("b_period_new", rises[1] - rises[0], 10);
    chk("b_drain_falls", falls, 8);
    chk("b_drain_no_fs", fs_extra, 0);
    chk("b_idle_busy", ifb.busy, 0);
    chk("b_idle_bclk", ifb.bclk, 0);
    chk("b_idle_lr", ifb.lrclk, 0);

    // div_half=0 runs bclk at clk/2
    dh_v[2] = 8'd0; en_v[2] = 1'b1;
    wait_for(S_CFS, 5, e);
    for (int k = 1; k <= 6; k++) begin
      @(negedge clk);
      chk("c_rise_alt", ifc.bclk_rise, k % 2);
      chk("c_fall_alt", ifc.bclk_fall, 1 - (k % 2));
    end

    // Reset while running
    rst = 1'b1;
    @(negedge clk);
    chk("rst_mid_vec", int'(act[2]), 0);
    chk("rst_mid_busy", ifc.busy, 0);
    rst = 1'b0;
    @(negedge clk);
    chk("rerun_busy", ifc.busy, 1);
    chk("rerun_fs", ifc.frame_start, 1);

    // Random run/stop/divider traffic against the model
    for (int i = 0; i < 3; i++) en_v[i] = 1'b1;
    for (int n = 0; n < 30000; n++) begin
      @(negedge clk);
      rst = ($urandom_range(0, 3999) == 0);
      for (int i = 0; i < 3; i++) begin
        if ($urandom_range(0, 149) == 0) en_v[i] = ~en_v[i];
        if ($urandom_range(0, 59) == 0)
          dh_v[i] = 8'($urandom_range(0, (i == 0) ? 4 : 6));
      end
    end
    rst = 1'b0;
    @(negedge clk);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
